shift_sequencer: RTL

//  Multi-cycle controller for the CPU's 8-bit shift/rotate path (sll, srl, sra, ror).

---
 rtl/shift_sequencer_pkg.sv | 37 +++
 rtl/shift_sequencer_if.sv | 30 +++
 rtl/shift_sequencer_bit_rev.sv | 17 +
 rtl/shift_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift/rotate sequencer.
// Contents:
//   sh_op_t    - shift opcode (sll, srl, sra, ror)
//   state_t    - sequencer FSM states
//   eff_count  - effective shift count from opcode and raw amount
package shift_sequencer_pkg;

    localparam int unsigned SEQ_WIDTH = 8;
    localparam int unsigned SEQ_CNT_W = 4;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } sh_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Shifts saturate at the full width; rotates wrap modulo the width.
    function automatic logic [SEQ_CNT_W-1:0] eff_count(input sh_op_t op, input logic [7:0] amount);
        logic [SEQ_CNT_W-1:0] n;
        if (op == SH_ROR) begin
            n = {1'b0, amount[2:0]};
        end else if (amount >= 8'd8) begin
            n = 4'd8;
        end else begin
            n = amount[3:0];
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the CPU and the shift sequencer.
// Signals:
//   START    - request strobe (CPU -> sequencer)
//   OPCODE   - 00 sll, 01 srl, 10 sra, 11 ror
//   DATA     - operand
//   AMOUNT   - unsigned shift amount
//   RESULT   - shifted value (sequencer -> CPU)
//   BUSYWAIT - stall request
//   DONE     - one-cycle completion pulse
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             START;
    logic [1:0]       OPCODE;
    logic [WIDTH-1:0] DATA;
    logic [7:0]       AMOUNT;
    logic [WIDTH-1:0] RESULT;
    logic             BUSYWAIT;
    logic             DONE;

    modport master (
        output START, OPCODE, DATA, AMOUNT,
        input  RESULT, BUSYWAIT, DONE
    );

    modport slave (
        input  START, OPCODE, DATA, AMOUNT,
        output RESULT, BUSYWAIT, DONE
    );
endinterface

// File: rtl/shift_sequencer_bit_rev.sv
// Combinational bit reversal: o_data[i] = i_data[WIDTH-1-i].
// Ports:
//   i_data - input word
//   o_data - bit-reversed word
module bit_rev #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    always_comb begin
        o_data = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            o_data[i] = i_data[WIDTH-1-i];
        end
    end
endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle controller for the 8-bit shift/rotate path.
// Shifts one bit per clock in a single left-shifting work register; right
// shifts are handled by bit-reversing the operand on load and the result
// on completion.
// Ports:
//   CLK   - system clock, rising edge
//   RESET - synchronous, active-high reset
//   bus   - slave side of shift_sequencer_if (START/OPCODE/DATA/AMOUNT in,
//           RESULT/BUSYWAIT/DONE out)
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    shift_sequencer_if.slave    bus
);

    state_t           r_state;
    state_t           w_state_next;
    sh_op_t           r_op;
    sh_op_t           w_op_in;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fill;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic             w_in_right;
    logic             w_op_right;
    logic [CNT_W-1:0] w_cnt_load;
    logic [WIDTH-1:0] w_load_rev;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_shift_rev;

    assign w_op_in    = sh_op_t'(bus.OPCODE);
    assign w_accept   = bus.START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cnt_load = CNT_W'(eff_count(w_op_in, bus.AMOUNT));
    assign w_last     = (r_cnt == CNT_W'(1));
    assign w_in_right = (w_op_in == SH_SRL) || (w_op_in == SH_SRA);
    assign w_op_right = (r_op == SH_SRL) || (r_op == SH_SRA);

    // Operand reversal for right shifts on the way in.
    bit_rev #(.WIDTH(WIDTH)) u_load_rev (
        .i_data (bus.DATA),
        .o_data (w_load_rev)
    );

    // Final reversal is taken from the post-shift value so RESULT is ready
    // in the same edge that enters DONE.
    bit_rev #(.WIDTH(WIDTH)) u_result_rev (
        .i_data (w_shifted),
        .o_data (w_shift_rev)
    );

    always_comb begin
        w_shifted = {r_work[WIDTH-2:0], r_fill};
        if (r_op == SH_ROR) begin
            w_shifted = {r_work[0], r_work[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.BUSYWAIT = w_accept || (r_state == ST_SHIFT);
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_next = (w_cnt_load == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_op     <= SH_SLL;
            r_work   <= '0;
            r_cnt    <= '0;
            r_fill   <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (w_state_next == ST_DONE);
            if (w_accept) begin
                r_op   <= w_op_in;
                r_work <= w_in_right ? w_load_rev : bus.DATA;
                r_cnt  <= w_cnt_load;
                r_fill <= (w_op_in == SH_SRA) ? bus.DATA[WIDTH-1] : 1'b0;
                if (w_cnt_load == '0) begin
                    r_result <= bus.DATA;
                end
            end else if (r_state == ST_SHIFT) begin
                r_work <= w_shifted;
                r_cnt  <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_result <= w_op_right ? w_shift_rev : w_shifted;
                end
            end
        end
    end

    assign bus.RESULT = r_result;
    assign bus.DONE   = r_done;

endmodule
